apo_input_arbiter: RTL and testbench

Input-side arbiter for the circulant (two-generator) router. It captures packets arriving on the five router inputs (IP core plus r1R, r2R, r1L, r2L) into one-entry holding slots. It presents exactly one packet per cycle to the routing datapath, chosen round-robin, so no simultaneous arrival is lost to fixed priority. It sits between the link/IP wires and the router's routing logic, applies backpressure per port, and counts protocol-violating drops.

---
 rtl/apo_input_arbiter.sv | 130 +++++++++++++
 tb/tb_apo_input_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/apo_input_arbiter.sv
// Five-port input arbiter: one-entry slot per port, round-robin grant into a single output register.
// Latency 2 cycles min (capture edge, grant edge); in_rdy = ~full, output stalls while out_valid & ~out_ready.
module apo_input_arbiter #(
  parameter int PKT_W = 17,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PKT_W-1:0] in_free,
  input  logic [PKT_W-1:0] in_r1R,
  input  logic [PKT_W-1:0] in_r2R,
  input  logic [PKT_W-1:0] in_r1L,
  input  logic [PKT_W-1:0] in_r2L,
  output logic [4:0]       in_rdy,
  output logic [PKT_W-1:0] out_pkt,
  output logic [2:0]       out_src,
  output logic             out_inph,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int NP = 5;

  logic [PKT_W-1:0] in_pkt [NP];
  logic [PKT_W-1:0] slot   [NP];
  logic [NP-1:0]    full;
  logic [NP-1:0]    in_vld;
  logic [NP-1:0]    drop_vec;
  logic [NP-1:0]    take_vec;
  logic [2:0]       last;
  logic [2:0]       gnt_idx;
  logic [2:0]       cand;
  logic [3:0]       csum;
  logic             gnt_vld;
  logic             load;
  logic [2:0]       drop_inc;
  logic [CNT_W+2:0] drop_sum;
  logic [CNT_W-1:0] drop_nxt;

  assign in_pkt[0] = in_free;
  assign in_pkt[1] = in_r1R;
  assign in_pkt[2] = in_r2R;
  assign in_pkt[3] = in_r1L;
  assign in_pkt[4] = in_r2L;

  for (genvar i = 0; i < NP; i++) begin : g_vld
    assign in_vld[i] = in_pkt[i][PKT_W-1];
  end

  assign in_rdy   = ~full;
  assign drop_vec = in_vld & full;
  assign load     = ~out_valid | out_ready;

  // Search starts one past the last winner so every full slot is served within five loads.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    csum    = '0;
    for (int k = 0; k < NP; k++) begin
      csum = {1'b0, last} + 4'(k) + 4'd1;
      cand = 3'(csum % 4'd5);
      if (!gnt_vld && full[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    take_vec = '0;
    for (int i = 0; i < NP; i++) begin
      take_vec[i] = load && gnt_vld && (gnt_idx == 3'(i));
    end
  end

  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < NP; i++) begin
      drop_inc = drop_inc + {2'b00, drop_vec[i]};
    end
    drop_sum = {3'b000, drop_cnt} + {{CNT_W{1'b0}}, drop_inc};
    drop_nxt = (drop_sum > {3'b000, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
  end

  // A slot drained on this edge cannot capture on it; a packet arriving then is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
      for (int i = 0; i < NP; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (!full[i] && in_vld[i]) begin
          slot[i] <= in_pkt[i];
          full[i] <= 1'b1;
        end else if (take_vec[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pkt   <= '0;
      out_src   <= '0;
      out_inph  <= 1'b0;
      out_valid <= 1'b0;
      last      <= 3'd4;
    end else if (load) begin
      if (gnt_vld) begin
        out_pkt   <= slot[gnt_idx];
        out_src   <= gnt_idx;
        out_inph  <= (gnt_idx != 3'd0);
        out_valid <= 1'b1;
        last      <= gnt_idx;
      end else begin
        out_pkt   <= '0;
        out_src   <= '0;
        out_inph  <= 1'b0;
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else        drop_cnt <= drop_nxt;
  end
endmodule

// File: tb/tb_apo_input_arbiter.sv
// Scoreboard bench: stimulus queues expected grants, a negedge monitor compares DUT output.
module tb_apo_input_arbiter;
  localparam int PKT_W = 17;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic [PKT_W-1:0] in_free, in_r1R, in_r2R, in_r1L, in_r2L;
  logic [4:0]       in_rdy;
  logic [PKT_W-1:0] out_pkt;
  logic [2:0]       out_src;
  logic             out_inph;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] drop_cnt;

  typedef struct {
    logic [PKT_W-1:0] pkt;
    logic [2:0]       src;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  apo_input_arbiter #(.PKT_W(PKT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_free(in_free), .in_r1R(in_r1R), .in_r2R(in_r2R), .in_r1L(in_r1L), .in_r2L(in_r2L),
    .in_rdy(in_rdy), .out_pkt(out_pkt), .out_src(out_src), .out_inph(out_inph),
    .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [PKT_W-1:0] f, a, b, c, d);
    in_free = f; in_r1R = a; in_r2R = b; in_r1L = c; in_r2L = d;
  endtask

  task automatic push(input logic [PKT_W-1:0] p, input logic [2:0] s);
    exp_t e;
    e.pkt = p;
    e.src = s;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0, '0, '0, '0, '0);
    #1;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
  endtask

  // Monitor: peek while stalled, pop on the edge where valid & ready transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got pkt 0x%0h src %0d, expected none", out_pkt, out_src);
        end else begin
          chk("out_pkt", 32'(out_pkt), 32'(exp_q[0].pkt));
          chk("out_src", 32'(out_src), 32'(exp_q[0].src));
          chk("out_inph", 32'(out_inph), 32'(exp_q[0].src != 3'd0));
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_pkt", 32'(out_pkt), 32'd0);
        chk("idle_src", 32'(out_src), 32'd0);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive('0, '0, '0, '0, '0);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pkt", 32'(out_pkt), 32'd0);
    chk("rst_src", 32'(out_src), 32'd0);
    chk("rst_inph", 32'(out_inph), 32'd0);
    chk("rst_rdy", 32'(in_rdy), 32'h1f);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    tick();
    rst_n = 1'b1;

    // Single packet from the IP core.
    out_ready = 1'b1;
    drive(17'h10005, '0, '0, '0, '0);
    push(17'h10005, 3'd0);
    tick();
    drive('0, '0, '0, '0, '0);
    chk("t1_rdy0", 32'(in_rdy[0]), 32'd0);
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    tick();
    chk("t1_valid_off", 32'(out_valid), 32'd0);
    chk("t1_pkt_off", 32'(out_pkt), 32'd0);

    // All five ports at once: served 0..4 back to back.
    do_reset();
    drive(17'h10001, 17'h10002, 17'h10003, 17'h10004, 17'h10005);
    for (int i = 0; i < 5; i++) push(17'(17'h10001 + i), 3'(i));
    tick();
    drive('0, '0, '0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_src_seq", 32'(out_src), 32'(i));
    end
    tick();
    chk("t2_drop", 32'(drop_cnt), 32'd0);
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // Stall with two slots full, then release.
    out_ready = 1'b0;
    drive('0, 17'h10011, '0, 17'h10033, '0);
    push(17'h10011, 3'd1);
    push(17'h10033, 3'd3);
    tick();
    drive('0, '0, '0, '0, '0);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_frozen_src", 32'(out_src), 32'd1);
      chk("t3_frozen_pkt", 32'(out_pkt), 32'h10011);
    end
    out_ready = 1'b1;
    tick();
    chk("t3_next_src", 32'(out_src), 32'd3);
    tick();
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // Occupy the output, then hold r2L valid: one capture, then drops up to saturation.
    do_reset();
    out_ready = 1'b0;
    drive(17'h10001, '0, '0, '0, '0);
    push(17'h10001, 3'd0);
    push(17'h10044, 3'd4);
    tick();
    drive('0, '0, '0, '0, '0);
    tick();
    drive('0, '0, '0, '0, 17'h10044);
    for (int i = 0; i < 3; i++) tick();
    chk("t4_drop2", 32'(drop_cnt), 32'd2);
    chk("t4_rdy4", 32'(in_rdy[4]), 32'd0);
    tick();
    chk("t5_drop3", 32'(drop_cnt), 32'd3);
    tick();
    tick();
    chk("t5_drop_sat", 32'(drop_cnt), 32'd3);
    drive('0, '0, '0, '0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while output valid and three slots full.
    out_ready = 1'b0;
    drive(17'h10021, 17'h10022, 17'h10023, 17'h10024, '0);
    push(17'h10021, 3'd0);
    tick();
    drive('0, '0, '0, '0, '0);
    tick();
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    chk("t6_pre_rdy", 32'(in_rdy), 32'h11);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_rdy", 32'(in_rdy), 32'h1f);
    chk("t6_async_drop", 32'(drop_cnt), 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(17'h10055, 17'h10066, '0, '0, '0);
    push(17'h10055, 3'd0);
    push(17'h10066, 3'd1);
    tick();
    drive('0, '0, '0, '0, '0);
    tick();
    chk("t6_first_src", 32'(out_src), 32'd0);
    tick();
    chk("t6_second_src", 32'(out_src), 32'd1);
    tick();
    tick();
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
